// File: rtl/mii_rx_pkg.sv
// Shared definitions for the MII receive path: preamble/SFD nibbles, the reflected
// CRC32 constants, and the receive FSM state encoding.
package mii_rx_pkg;

  localparam logic [3:0]  PreambleNib  = 4'h5;
  localparam logic [3:0]  SfdNib       = 4'hD;
  localparam logic [31:0] Crc32PolyR   = 32'hEDB88320;
  localparam logic [31:0] Crc32Init    = 32'hFFFFFFFF;
  // Register value after a frame's data plus its correct FCS has been shifted in.
  localparam logic [31:0] Crc32Residue = 32'hDEBB20E3;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPre  = 2'd1,
    StData = 2'd2,
    StDrop = 2'd3
  } rx_state_e;

endpackage

// File: rtl/crc32_d8.sv
// Combinational byte-wise CRC32 step (reflected polynomial, LSB first).
// Ports:
//   crc_in  - current CRC register
//   data    - byte to absorb
//   crc_out - CRC register after absorbing data
module crc32_d8
  import mii_rx_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  always_comb begin
    crc_out = crc_in ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      crc_out = crc_out[0] ? ((crc_out >> 1) ^ Crc32PolyR) : (crc_out >> 1);
    end
  end

endmodule

// File: rtl/mii_rx.sv
// MII receive front end. Registers the PHY nibble stream once, strips preamble/SFD,
// assembles bytes (low nibble first), checks the FCS and frame length, and presents a
// byte stream with start/end markers plus a per-frame done/good verdict.
// Ports:
//   clk, reset              - MII RX clock, asynchronous active-low reset
//   mii_rx_dv/er/rxd        - PHY receive data valid, error, nibble
//   rx_data, rx_valid       - frame byte and its 1-cycle strobe
//   rx_start, rx_end        - first / last byte markers (only with rx_valid)
//   rx_done, rx_good        - frame closing pulse and its verdict
//   rx_bad_cnt              - saturating count of frames closed bad
module mii_rx
  import mii_rx_pkg::*;
#(
  parameter int unsigned MIN_PRE_NIB = 6,
  parameter int unsigned MIN_BYTES   = 64,
  parameter int unsigned MAX_BYTES   = 1518
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mii_rx_dv,
  input  logic        mii_rx_er,
  input  logic [3:0]  mii_rxd,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_start,
  output logic        rx_end,
  output logic        rx_done,
  output logic        rx_good,
  output logic [15:0] rx_bad_cnt
);

  localparam logic [3:0]  MinPre   = 4'(MIN_PRE_NIB);
  localparam logic [10:0] MinBytes = 11'(MIN_BYTES);
  localparam logic [10:0] MaxBytes = 11'(MAX_BYTES);

  logic        dv_q, er_q;
  logic [3:0]  rxd_q;
  rx_state_e   state_q, state_d;
  logic [3:0]  pre_cnt_q, pre_cnt_d;
  logic [3:0]  low_q, low_d;
  logic        phase_q, phase_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_vld_q, hold_vld_d;
  logic        emitted_q, emitted_d;
  logic [10:0] byte_cnt_q, byte_cnt_d, byte_new;
  logic [31:0] crc_q, crc_d, crc_next;
  logic        fin_pend_q, fin_pend_d, fin_good_q, fin_good_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d, start_q, start_d, end_q, end_d;
  logic        done_q, done_d, good_q, good_d;
  logic [15:0] bad_cnt_q, bad_cnt_d;

  crc32_d8 u_crc (
    .crc_in  (crc_q),
    .data    ({rxd_q, low_q}),
    .crc_out (crc_next)
  );

  assign byte_new = (byte_cnt_q == 11'h7FF) ? byte_cnt_q : byte_cnt_q + 11'd1;

  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    low_d      = low_q;
    phase_d    = phase_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    emitted_d  = emitted_q;
    byte_cnt_d = byte_cnt_q;
    crc_d      = crc_q;
    fin_pend_d = 1'b0;
    fin_good_d = 1'b0;
    data_d     = 8'h00;
    valid_d    = 1'b0;
    start_d    = 1'b0;
    end_d      = 1'b0;
    // A normal frame end closes with rx_done one cycle after the rx_end byte.
    done_d     = fin_pend_q;
    good_d     = fin_pend_q & fin_good_q;
    bad_cnt_d  = bad_cnt_q;
    if (done_q && !good_q && (bad_cnt_q != 16'hFFFF)) begin
      bad_cnt_d = bad_cnt_q + 16'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (dv_q) begin
          if (rxd_q == PreambleNib) begin
            state_d   = StPre;
            pre_cnt_d = 4'd1;
          end else begin
            state_d = StDrop;
          end
        end
      end
      StPre: begin
        if (!dv_q) begin
          state_d = StIdle;
        end else if (er_q) begin
          state_d = StDrop;
        end else if (rxd_q == PreambleNib) begin
          if (pre_cnt_q != 4'hF) pre_cnt_d = pre_cnt_q + 4'd1;
        end else if ((rxd_q == SfdNib) && (pre_cnt_q >= MinPre)) begin
          state_d    = StData;
          phase_d    = 1'b0;
          hold_vld_d = 1'b0;
          emitted_d  = 1'b0;
          byte_cnt_d = 11'd0;
          crc_d      = Crc32Init;
        end else begin
          state_d = StDrop;
        end
      end
      StData: begin
        if (!dv_q) begin
          // Flush the held byte as the last one; a dangling low nibble is dropped.
          state_d    = StIdle;
          hold_vld_d = 1'b0;
          if (hold_vld_q) begin
            valid_d    = 1'b1;
            data_d     = hold_q;
            start_d    = ~emitted_q;
            end_d      = 1'b1;
            fin_pend_d = 1'b1;
            fin_good_d = (crc_q == Crc32Residue) && (byte_cnt_q >= MinBytes) &&
                         (byte_cnt_q <= MaxBytes) && !phase_q;
          end
        end else if (er_q || (phase_q && (byte_new > MaxBytes))) begin
          // Abort: held byte is discarded; close only a frame that was already opened.
          state_d    = StDrop;
          hold_vld_d = 1'b0;
          if (emitted_q) begin
            done_d = 1'b1;
            good_d = 1'b0;
          end
        end else if (!phase_q) begin
          low_d   = rxd_q;
          phase_d = 1'b1;
        end else begin
          phase_d    = 1'b0;
          byte_cnt_d = byte_new;
          crc_d      = crc_next;
          hold_d     = {rxd_q, low_q};
          hold_vld_d = 1'b1;
          if (hold_vld_q) begin
            valid_d   = 1'b1;
            data_d    = hold_q;
            start_d   = ~emitted_q;
            emitted_d = 1'b1;
          end
        end
      end
      StDrop: begin
        if (!dv_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dv_q       <= 1'b0;
      er_q       <= 1'b0;
      rxd_q      <= 4'h0;
      state_q    <= StIdle;
      pre_cnt_q  <= 4'd0;
      low_q      <= 4'h0;
      phase_q    <= 1'b0;
      hold_q     <= 8'h00;
      hold_vld_q <= 1'b0;
      emitted_q  <= 1'b0;
      byte_cnt_q <= 11'd0;
      crc_q      <= Crc32Init;
      fin_pend_q <= 1'b0;
      fin_good_q <= 1'b0;
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      start_q    <= 1'b0;
      end_q      <= 1'b0;
      done_q     <= 1'b0;
      good_q     <= 1'b0;
      bad_cnt_q  <= 16'd0;
    end else begin
      dv_q       <= mii_rx_dv;
      er_q       <= mii_rx_er;
      rxd_q      <= mii_rxd;
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      low_q      <= low_d;
      phase_q    <= phase_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      emitted_q  <= emitted_d;
      byte_cnt_q <= byte_cnt_d;
      crc_q      <= crc_d;
      fin_pend_q <= fin_pend_d;
      fin_good_q <= fin_good_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      start_q    <= start_d;
      end_q      <= end_d;
      done_q     <= done_d;
      good_q     <= good_d;
      bad_cnt_q  <= bad_cnt_d;
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign rx_start   = start_q;
  assign rx_end     = end_q;
  assign rx_done    = done_q;
  assign rx_good    = good_q;
  assign rx_bad_cnt = bad_cnt_q;

endmodule

// File: tb/tb_mii_rx.sv
// Directed bench for mii_rx: builds frames with a locally computed FCS, drives them
// nibble by nibble and checks the collected byte stream and frame verdicts.
module tb_mii_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic        dv, er;
  logic [3:0]  rxd;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_start, rx_end, rx_done, rx_good;
  logic [15:0] rx_bad_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mii_rx dut (
    .clk        (clk),
    .reset      (reset),
    .mii_rx_dv  (dv),
    .mii_rx_er  (er),
    .mii_rxd    (rxd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_start   (rx_start),
    .rx_end     (rx_end),
    .rx_done    (rx_done),
    .rx_good    (rx_good),
    .rx_bad_cnt (rx_bad_cnt)
  );

  // Output collector, sampled on the falling edge.
  logic [7:0] got [$];
  int         n_start, n_end, n_done, n_goods, n_stray, start_pos, end_pos;
  logic [7:0] end_byte;

  always @(negedge clk) begin
    if (rx_valid) begin
      if (rx_start) begin n_start++; start_pos = got.size(); end
      if (rx_end) begin n_end++; end_pos = got.size(); end_byte = rx_data; end
      got.push_back(rx_data);
    end else if (rx_start || rx_end) begin
      n_stray++;
    end
    if (rx_done) begin
      n_done++;
      if (rx_good) n_goods++;
    end else if (rx_good) begin
      n_stray++;
    end
  end

  logic [7:0] frm [0:1599];
  int         frm_len;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h000000, d};
    for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Payload byte i = i[7:0], followed by the FCS (complemented CRC, LSB first).
  task automatic build_frame(input int len);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < len - 4; i++) begin
      frm[i] = 8'(i);
      c = crc_byte(c, frm[i]);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) frm[len-4+k] = c[8*k +: 8];
    frm_len = len;
  endtask

  task automatic nib(input logic v, input logic e, input logic [3:0] d);
    @(posedge clk);
    #1;
    dv  = v;
    er  = e;
    rxd = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) nib(1'b0, 1'b0, 4'h0);
  endtask

  task automatic drive_frame(input int pre_n, input int nbytes, input int er_at);
    for (int i = 0; i < pre_n; i++) nib(1'b1, 1'b0, 4'h5);
    nib(1'b1, 1'b0, 4'hD);
    for (int i = 0; i < nbytes; i++) begin
      nib(1'b1, (i == er_at), frm[i][3:0]);
      nib(1'b1, (i == er_at), frm[i][7:4]);
    end
  endtask

  task automatic clear_mon();
    got.delete();
    n_start = 0; n_end = 0; n_done = 0; n_goods = 0; n_stray = 0;
    start_pos = -1; end_pos = -1; end_byte = 8'h00;
  endtask

  function automatic int payload_mism(input int n);
    int m;
    m = 0;
    for (int i = 0; i < n && i < got.size(); i++) if (got[i] !== frm[i]) m++;
    return m;
  endfunction

  task automatic test_reset();
    reset = 1'b0; dv = 1'b0; er = 1'b0; rxd = 4'h0;
    #2;
    n_vec++;
    if ({rx_data, rx_valid, rx_start, rx_end, rx_done, rx_good} !== 13'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h, want 0",
               {rx_data, rx_valid, rx_start, rx_end, rx_done, rx_good});
    end
    n_vec++;
    if (rx_bad_cnt !== 16'h0) begin
      n_err++; $display("FAIL reset_bad_cnt: got %0d, want 0", rx_bad_cnt);
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    idle(2);
    clear_mon();
  endtask

  task automatic test_good_frame();
    clear_mon();
    build_frame(64);
    drive_frame(15, 64, -1);
    idle(8);
    n_vec++; if (got.size() !== 64) begin n_err++; $display("FAIL good_len: got %0d, want 64", got.size()); end
    n_vec++; if (payload_mism(64) !== 0) begin n_err++; $display("FAIL good_bytes: %0d bytes differ, want 0", payload_mism(64)); end
    n_vec++; if (start_pos !== 0 || n_start !== 1) begin n_err++; $display("FAIL good_start: pos %0d cnt %0d, want 0/1", start_pos, n_start); end
    n_vec++; if (end_pos !== 63 || n_end !== 1) begin n_err++; $display("FAIL good_end: pos %0d cnt %0d, want 63/1", end_pos, n_end); end
    n_vec++; if (n_done !== 1 || n_goods !== 1) begin n_err++; $display("FAIL good_done: done %0d good %0d, want 1/1", n_done, n_goods); end
    n_vec++; if (n_stray !== 0) begin n_err++; $display("FAIL good_stray: got %0d, want 0", n_stray); end
    n_vec++; if (rx_bad_cnt !== 16'd0) begin n_err++; $display("FAIL good_bad_cnt: got %0d, want 0", rx_bad_cnt); end
  endtask

  task automatic test_bad_fcs();
    clear_mon();
    build_frame(64);
    frm[63] = frm[63] ^ 8'h01;
    drive_frame(15, 64, -1);
    idle(8);
    n_vec++; if (got.size() !== 64 || n_end !== 1) begin n_err++; $display("FAIL fcs_len: got %0d end %0d, want 64/1", got.size(), n_end); end
    n_vec++; if (n_done !== 1 || n_goods !== 0) begin n_err++; $display("FAIL fcs_done: done %0d good %0d, want 1/0", n_done, n_goods); end
    n_vec++; if (rx_bad_cnt !== 16'd1) begin n_err++; $display("FAIL fcs_bad_cnt: got %0d, want 1", rx_bad_cnt); end
  endtask

  task automatic test_rx_er();
    clear_mon();
    build_frame(64);
    drive_frame(15, 64, 20);
    idle(8);
    n_vec++; if (got.size() !== 19) begin n_err++; $display("FAIL er_len: got %0d, want 19", got.size()); end
    n_vec++; if (payload_mism(19) !== 0) begin n_err++; $display("FAIL er_bytes: %0d differ, want 0", payload_mism(19)); end
    n_vec++; if (n_start !== 1 || n_end !== 0) begin n_err++; $display("FAIL er_marks: start %0d end %0d, want 1/0", n_start, n_end); end
    n_vec++; if (n_done !== 1 || n_goods !== 0) begin n_err++; $display("FAIL er_done: done %0d good %0d, want 1/0", n_done, n_goods); end
    n_vec++; if (rx_bad_cnt !== 16'd2) begin n_err++; $display("FAIL er_bad_cnt: got %0d, want 2", rx_bad_cnt); end
  endtask

  task automatic test_short_preamble();
    clear_mon();
    build_frame(64);
    drive_frame(4, 64, -1);
    idle(8);
    n_vec++; if (got.size() !== 0 || n_done !== 0) begin n_err++; $display("FAIL pre4_out: bytes %0d done %0d, want 0/0", got.size(), n_done); end
    // Exactly the minimum preamble length is accepted.
    clear_mon();
    drive_frame(6, 64, -1);
    idle(8);
    n_vec++; if (got.size() !== 64 || n_goods !== 1) begin n_err++; $display("FAIL pre6_frame: bytes %0d good %0d, want 64/1", got.size(), n_goods); end
    n_vec++; if (rx_bad_cnt !== 16'd2) begin n_err++; $display("FAIL pre_bad_cnt: got %0d, want 2", rx_bad_cnt); end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    for (int i = 0; i < 40; i++) frm[i] = 8'(i);
    frm[40] = 8'h12;
    frm_len = 41;
    drive_frame(15, 41, -1);
    nib(1'b1, 1'b0, 4'hA);
    idle(12);
    n_vec++; if (got.size() !== 41) begin n_err++; $display("FAIL odd_len: got %0d, want 41", got.size()); end
    n_vec++; if (end_byte !== 8'h12 || n_end !== 1) begin n_err++; $display("FAIL odd_last: got %h end %0d, want 12/1", end_byte, n_end); end
    n_vec++; if (n_done !== 1 || n_goods !== 0) begin n_err++; $display("FAIL odd_done: done %0d good %0d, want 1/0", n_done, n_goods); end
    n_vec++; if (rx_bad_cnt !== 16'd3) begin n_err++; $display("FAIL odd_bad_cnt: got %0d, want 3", rx_bad_cnt); end
    clear_mon();
    build_frame(64);
    drive_frame(15, 64, -1);
    idle(8);
    n_vec++; if (got.size() !== 64 || n_goods !== 1) begin n_err++; $display("FAIL b2b_frame: bytes %0d good %0d, want 64/1", got.size(), n_goods); end
    n_vec++; if (payload_mism(64) !== 0) begin n_err++; $display("FAIL b2b_bytes: %0d differ, want 0", payload_mism(64)); end
  endtask

  task automatic test_tiny_frames();
    clear_mon();
    frm[0] = 8'hA7;
    drive_frame(15, 1, -1);
    idle(8);
    n_vec++; if (got.size() !== 1 || end_byte !== 8'hA7) begin n_err++; $display("FAIL one_byte: bytes %0d data %h, want 1/a7", got.size(), end_byte); end
    n_vec++; if (start_pos !== 0 || end_pos !== 0) begin n_err++; $display("FAIL one_marks: start %0d end %0d, want 0/0", start_pos, end_pos); end
    n_vec++; if (n_done !== 1 || n_goods !== 0) begin n_err++; $display("FAIL one_done: done %0d good %0d, want 1/0", n_done, n_goods); end
    clear_mon();
    drive_frame(15, 0, -1);
    idle(8);
    n_vec++; if (got.size() !== 0 || n_done !== 0) begin n_err++; $display("FAIL zero_byte: bytes %0d done %0d, want 0/0", got.size(), n_done); end
    n_vec++; if (rx_bad_cnt !== 16'd4) begin n_err++; $display("FAIL tiny_bad_cnt: got %0d, want 4", rx_bad_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    clear_mon();
    build_frame(1518);
    drive_frame(15, 30, -1);
    reset = 1'b0;
    dv    = 1'b0;
    #1;
    n_vec++;
    if ({rx_data, rx_valid, rx_start, rx_end, rx_done, rx_good, rx_bad_cnt} !== 29'h0) begin
      n_err++;
      $display("FAIL midreset_outputs: got %h, want 0",
               {rx_data, rx_valid, rx_start, rx_end, rx_done, rx_good, rx_bad_cnt});
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    idle(6);
    n_vec++; if (n_done !== 0) begin n_err++; $display("FAIL midreset_done: got %0d, want 0", n_done); end
    clear_mon();
    build_frame(64);
    drive_frame(15, 64, -1);
    idle(8);
    n_vec++; if (got.size() !== 64 || n_goods !== 1) begin n_err++; $display("FAIL post_reset_frame: bytes %0d good %0d, want 64/1", got.size(), n_goods); end
  endtask

  task automatic test_oversize();
    clear_mon();
    build_frame(1518);
    drive_frame(15, 1518, -1);
    idle(8);
    n_vec++; if (got.size() !== 1518 || n_goods !== 1) begin n_err++; $display("FAIL max_frame: bytes %0d good %0d, want 1518/1", got.size(), n_goods); end
    n_vec++; if (payload_mism(1518) !== 0) begin n_err++; $display("FAIL max_bytes: %0d differ, want 0", payload_mism(1518)); end
    clear_mon();
    build_frame(1519);
    drive_frame(15, 1519, -1);
    idle(8);
    n_vec++; if (got.size() !== 1517 || n_end !== 0) begin n_err++; $display("FAIL over_len: bytes %0d end %0d, want 1517/0", got.size(), n_end); end
    n_vec++; if (n_done !== 1 || n_goods !== 0) begin n_err++; $display("FAIL over_done: done %0d good %0d, want 1/0", n_done, n_goods); end
    n_vec++; if (rx_bad_cnt !== 16'd1) begin n_err++; $display("FAIL over_bad_cnt: got %0d, want 1", rx_bad_cnt); end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_good_frame();
    test_bad_fcs();
    test_rx_er();
    test_short_preamble();
    test_back_to_back();
    test_tiny_frames();
    test_reset_mid_frame();
    test_oversize();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
